dog_img: RTL and testbench
==========================

Name: dog_img

Overview:
- Difference-of-Gaussians stage, directly downstream of the blur stage.
- Reads two blurred images of identical size from two BRAMs, one per adjacent blur scale, using a shared address.
- Writes the signed per-pixel difference (a - b) into a third BRAM for the keypoint extrema stage.
- Start/done pulse handshake, same as the blur stage; a sequencer chains the two.

Parameters:
- BIT_DEPTH, 8, unsigned input pixel width.
- WIDTH, 64, image width in pixels.
- HEIGHT, 64, image height in pixels.

Ports:
- clk_in  input  1  system clock; all logic on posedge.
- rst_in  input  1  reset, synchronous and active-high.
- ext_read_addr  output  $clog2(WIDTH*HEIGHT)  address driven to both source BRAMs.
- ext_read_addr_valid  output  1  address valid (read enable).
- ext_pixel_a_in  input  BIT_DEPTH  BRAM A data (less-blurred scale).
- ext_pixel_b_in  input  BIT_DEPTH  BRAM B data (more-blurred scale).
- ext_write_addr  output  $clog2(WIDTH*HEIGHT)  destination BRAM address.
- ext_write_valid  output  1  destination write enable.
- ext_pixel_out  output  BIT_DEPTH+1  signed two's-complement difference.
- start_in  input  1  one-cycle pulse; begin a pass.
- dog_done  output  1  one-cycle pulse; pass complete.
- busy_out  output  1  pass in progress.

Behaviour:
- Clock and reset: one clock (clk_in); reset is synchronous and active-high (rst_in).
- Reset: all outputs are 0, state is IDLE, and all pipeline valids are cleared. Reset mid-pass aborts immediately. No further reads or writes occur, and no dog_done is issued.
- States: IDLE, READ, DRAIN.
- IDLE:
  - start_in=1 moves to READ.
  - The address counter is cleared to 0.
- READ:
  - Each cycle, ext_read_addr equals the counter, ext_read_addr_valid=1, and the counter increments.
  - After issuing address N-1 (N=WIDTH*HEIGHT), go to DRAIN.
  - Reads are fully pipelined: one address per cycle, no gaps.
- DRAIN:
  - Wait until the last write issues, then pulse dog_done and return to IDLE.
- BRAM read latency is fixed at 2 cycles: data for the address issued at cycle t is on ext_pixel_*_in at t+2.
- A read-valid/address delay line of depth 2 tracks in-flight reads. The delay line is internal and not shared with the sources.
- Compute:
  - Zero-extend both inputs to BIT_DEPTH+1 bits, then subtract a - b.
  - The result is registered once, giving write at t+3 with ext_write_addr = the address issued at t.
  - No saturation is needed; the range is -(2^BIT_DEPTH-1) to +(2^BIT_DEPTH-1).
- Timing, with start accepted at cycle T:
  - Address k issues at T+1+k.
  - Write k occurs at T+4+k.
  - dog_done is at T+N+4, one cycle after the last write.
- busy_out is 1 from T+1 through the dog_done cycle inclusive, and 0 on the following cycle.
- Output hold: ext_write_valid is exactly one cycle per pixel, and the write addresses are strictly ascending with no repeats.
- ext_read_addr holds its last value when valid=0.
- start_in while busy_out=1 is ignored, with no restart and no effect on counters.
- start_in in the cycle after dog_done is accepted (back-to-back passes).
- Write-order guarantee: every address 0..N-1 is written exactly once per pass.

Decomposition:
- Shared package sift_pkg:
  - SRC_READ_LATENCY = 2.
  - Typedef for the state enum (IDLE/READ/DRAIN).
  - Helper function pix_addr_width(w,h) = $clog2(w*h), reused by the blur and extrema stages.
- One sub-module, dog_sub:
  - Registered subtractor with valid/addr passthrough, 1-cycle latency.
  - Parameterised on BIT_DEPTH and address width.
  - Keeps the arithmetic separately testable.

Test Plan:
- Use WIDTH=HEIGHT=4 (N=16) for all scenarios, with BRAM models of latency 2.
- Constant positive: A=100, B=40 everywhere, start -> 16 writes of 9'd60 at addrs 0..15 on consecutive cycles T+4..T+19, dog_done at T+20.
- Negative/extremes: A[i]=0 and B[i]=255 for even i; A[i]=255 and B[i]=0 for odd i -> even outputs 9'h101 (-255), odd outputs 9'h0FF (+255); A=10, B=200 -> 9'h142 (-190).
- Ramp address check: A[i]=i*8, B[i]=i -> out[i]=7*i; write addr equals pixel index; each address exactly once.
- Start while busy: pulse start_in again at T+6 -> no restart; same 16 writes; single dog_done at T+20.
- Reset mid-pass: assert rst_in at T+8 for one cycle -> from T+9 all outputs 0, no dog_done. A new start afterwards completes a full, correct pass.
- Back-to-back: start_in in the cycle after dog_done -> second pass accepted; busy_out low for exactly one cycle between passes; outputs identical to the first pass.

Source files
------------

// File: rtl/sift_pkg.sv
// Shared definitions for the SIFT pipeline stages (blur, DoG, extrema).
// Contents:
//   SRC_READ_LATENCY - fixed read latency of the source BRAMs, in cycles
//   dog_state_e      - sequencing states of a pass (IDLE/READ/DRAIN)
//   pix_addr_width   - address width needed to cover a w x h image
package sift_pkg;

  localparam int SRC_READ_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } dog_state_e;

  function automatic int pix_addr_width(input int w, input int h);
    return $clog2(w * h);
  endfunction

endpackage

// File: rtl/dog_img_if.sv
// Bus bundle of the DoG stage: source BRAM read port (shared address,
// two data lanes), destination BRAM write port and the start/done/busy
// pass handshake.
//   master - the DoG stage (drives addresses, write data, done, busy)
//   slave  - the memories and the sequencer around it
interface dog_img_if #(
  parameter int BIT_DEPTH = 8,
  parameter int ADDR_W    = 12
);

  logic [ADDR_W-1:0]    ext_read_addr;
  logic                 ext_read_addr_valid;
  logic [BIT_DEPTH-1:0] ext_pixel_a_in;
  logic [BIT_DEPTH-1:0] ext_pixel_b_in;
  logic [ADDR_W-1:0]    ext_write_addr;
  logic                 ext_write_valid;
  logic [BIT_DEPTH:0]   ext_pixel_out;
  logic                 start_in;
  logic                 dog_done;
  logic                 busy_out;

  modport master (
    output ext_read_addr, ext_read_addr_valid,
    input  ext_pixel_a_in, ext_pixel_b_in,
    output ext_write_addr, ext_write_valid, ext_pixel_out,
    input  start_in,
    output dog_done, busy_out
  );

  modport slave (
    input  ext_read_addr, ext_read_addr_valid,
    output ext_pixel_a_in, ext_pixel_b_in,
    input  ext_write_addr, ext_write_valid, ext_pixel_out,
    output start_in,
    input  dog_done, busy_out
  );

endinterface

// File: rtl/dog_img_sub.sv
// dog_sub: registered subtractor with valid/address passthrough.
// Both pixels are zero-extended by one bit so the difference a - b is an
// exact two's-complement value; one cycle of latency.
// Ports:
//   clk_in, rst_in     - clock, synchronous active-high reset
//   src_valid/src_addr - qualifier and address aligned with pix_a/pix_b
//   pix_a, pix_b       - unsigned source pixels
//   diff_valid/addr    - registered qualifier and address
//   diff               - registered signed difference (BIT_DEPTH+1 bits)
module dog_sub #(
  parameter int BIT_DEPTH = 8,
  parameter int ADDR_W    = 12
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 src_valid,
  input  logic [ADDR_W-1:0]    src_addr,
  input  logic [BIT_DEPTH-1:0] pix_a,
  input  logic [BIT_DEPTH-1:0] pix_b,
  output logic                 diff_valid,
  output logic [ADDR_W-1:0]    diff_addr,
  output logic [BIT_DEPTH:0]   diff
);

  logic [BIT_DEPTH:0]  diff_s;
  logic                valid_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [BIT_DEPTH:0]  diff_r;

  // Exact difference; range never exceeds +/-(2^BIT_DEPTH-1), so no clamp.
  always_comb begin
    diff_s = {1'b0, pix_a} - {1'b0, pix_b};
  end

  // Output register; data and address only move on a valid sample.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_r <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      diff_r  <= {(BIT_DEPTH+1){1'b0}};
    end else begin
      valid_r <= src_valid;
      if (src_valid) begin
        addr_r <= src_addr;
        diff_r <= diff_s;
      end
    end
  end

  assign diff_valid = valid_r;
  assign diff_addr  = addr_r;
  assign diff       = diff_r;

endmodule

// File: rtl/dog_img.sv
// dog_img: Difference-of-Gaussians stage. Streams two equally sized blurred
// images out of two BRAMs with one shared address per cycle and writes the
// signed per-pixel difference (a - b) to a destination BRAM in address order.
// Ports:
//   clk_in - system clock, rising edge
//   rst_in - synchronous active-high reset; aborts a pass immediately
//   bus    - dog_img_if.master: read port, write port, start/done/busy
module dog_img
  import sift_pkg::*;
#(
  parameter int BIT_DEPTH = 8,
  parameter int WIDTH     = 64,
  parameter int HEIGHT    = 64
) (
  input  logic      clk_in,
  input  logic      rst_in,
  dog_img_if.master bus
);

  localparam int ADDR_W = pix_addr_width(WIDTH, HEIGHT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

  dog_state_e                  state_r, state_s;
  logic [ADDR_W-1:0]           cnt_r, cnt_s;
  logic [ADDR_W-1:0]           rd_addr_r, rd_addr_s;
  logic                        rd_valid_r, rd_valid_s;
  logic                        done_r, done_s;
  logic                        busy_r, busy_s;
  logic [SRC_READ_LATENCY-1:0] dl_valid_r;
  logic [ADDR_W-1:0]           dl_addr_r [SRC_READ_LATENCY];
  logic                        wr_valid_s;
  logic [ADDR_W-1:0]           wr_addr_s;
  logic [BIT_DEPTH:0]          wr_pix_s;

  // Next-state and registered-output values of the pass sequencer.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    rd_addr_s  = rd_addr_r;
    rd_valid_s = 1'b0;
    done_s     = 1'b0;
    case (state_r)
      IDLE: begin
        // busy_r is still high in the dog_done cycle, so a start there is
        // dropped; the first accepted start is the cycle after dog_done.
        if (bus.start_in && !busy_r) begin
          state_s    = READ;
          rd_addr_s  = {ADDR_W{1'b0}};
          rd_valid_s = 1'b1;
          cnt_s      = ADDR_W'(1);
        end else begin
          cnt_s = {ADDR_W{1'b0}};
        end
      end
      READ: begin
        if (rd_addr_r == LAST_ADDR) begin
          state_s = DRAIN;
        end else begin
          rd_addr_s  = cnt_r;
          rd_valid_s = 1'b1;
          cnt_s      = cnt_r + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (wr_valid_s && (wr_addr_s == LAST_ADDR)) begin
          state_s = IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE) || done_s;
  end

  // Sequencer state and its registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r    <= IDLE;
      cnt_r      <= {ADDR_W{1'b0}};
      rd_addr_r  <= {ADDR_W{1'b0}};
      rd_valid_r <= 1'b0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      rd_addr_r  <= rd_addr_s;
      rd_valid_r <= rd_valid_s;
      done_r     <= done_s;
      busy_r     <= busy_s;
    end
  end

  // In-flight read tracker: the last stage lines up with BRAM data.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      dl_valid_r <= {SRC_READ_LATENCY{1'b0}};
      for (int i = 0; i < SRC_READ_LATENCY; i++) begin
        dl_addr_r[i] <= {ADDR_W{1'b0}};
      end
    end else begin
      dl_valid_r[0] <= rd_valid_r;
      dl_addr_r[0]  <= rd_addr_r;
      for (int i = 1; i < SRC_READ_LATENCY; i++) begin
        dl_valid_r[i] <= dl_valid_r[i-1];
        dl_addr_r[i]  <= dl_addr_r[i-1];
      end
    end
  end

  dog_sub #(
    .BIT_DEPTH (BIT_DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_sub (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .src_valid  (dl_valid_r[SRC_READ_LATENCY-1]),
    .src_addr   (dl_addr_r[SRC_READ_LATENCY-1]),
    .pix_a      (bus.ext_pixel_a_in),
    .pix_b      (bus.ext_pixel_b_in),
    .diff_valid (wr_valid_s),
    .diff_addr  (wr_addr_s),
    .diff       (wr_pix_s)
  );

  assign bus.ext_read_addr       = rd_addr_r;
  assign bus.ext_read_addr_valid = rd_valid_r;
  assign bus.ext_write_addr      = wr_addr_s;
  assign bus.ext_write_valid     = wr_valid_s;
  assign bus.ext_pixel_out       = wr_pix_s;
  assign bus.dog_done            = done_r;
  assign bus.busy_out            = busy_r;

endmodule

// File: tb/tb_dog_img.sv
// Testbench for dog_img on a 4x4 image with two latency-2 BRAM models.
// A scoreboard logs reads, writes, dog_done and busy per cycle; each pass is
// then compared with the expected schedule and arithmetic derived directly
// from the stage's timing rules (start at T: read k at T+1+k, write k at
// T+4+k, done at T+N+4).
module tb_dog_img;

  localparam int N    = 16;
  localparam int LOGN = 4096;

  typedef struct {
    int cyc;
    int addr;
    int data;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [7:0] mem_a [N];
  logic [7:0] mem_b [N];
  logic [7:0] a_p1, a_p2, b_p1, b_p2;

  ev_t  wr_q[$];
  ev_t  rd_q[$];
  int   done_q[$];
  bit   busy_log [LOGN];
  bit   out_log  [LOGN];

  dog_img_if #(.BIT_DEPTH(8), .ADDR_W(4)) bus ();

  dog_img #(.BIT_DEPTH(8), .WIDTH(4), .HEIGHT(4)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Source BRAMs: data for the address seen at cycle t appears at t+2.
  always @(posedge clk) begin
    a_p1 <= mem_a[bus.ext_read_addr];
    b_p1 <= mem_b[bus.ext_read_addr];
    a_p2 <= a_p1;
    b_p2 <= b_p1;
  end
  assign bus.ext_pixel_a_in = a_p2;
  assign bus.ext_pixel_b_in = b_p2;

  // Scoreboard capture on the falling edge.
  always @(negedge clk) begin
    if (cyc < LOGN) begin
      busy_log[cyc] = bus.busy_out;
      out_log[cyc]  = (bus.ext_read_addr != 4'd0) || bus.ext_read_addr_valid ||
                      (bus.ext_write_addr != 4'd0) || bus.ext_write_valid ||
                      (bus.ext_pixel_out != 9'd0) || bus.dog_done || bus.busy_out;
    end
    if (bus.ext_write_valid) wr_q.push_back('{cyc, int'(bus.ext_write_addr), int'(bus.ext_pixel_out)});
    if (bus.ext_read_addr_valid) rd_q.push_back('{cyc, int'(bus.ext_read_addr), 0});
    if (bus.dog_done) done_q.push_back(cyc);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_diff(input int a, input int b);
    return (a - b) & 511;
  endfunction

  task automatic clear_logs();
    wr_q.delete();
    rd_q.delete();
    done_q.delete();
  endtask

  // One full pass started now; extra_start > 0 pulses start again at T+extra_start.
  task automatic run_pass(input string tag, input int extra_start);
    int t0;
    int waited;
    int nuniq;
    int busy_sum;
    bit seen [N];
    clear_logs();
    t0 = cyc;
    bus.start_in = 1'b1;
    waited = 0;
    do begin
      @(negedge clk); #1;
      waited++;
      bus.start_in = (extra_start > 0) && (cyc == t0 + extra_start);
    end while (done_q.size() == 0 && waited < N + 30);
    @(negedge clk); #1;
    bus.start_in = 1'b0;
    check_eq({tag, "_done_count"}, done_q.size(), 1);
    check_eq({tag, "_done_cycle"}, (done_q.size() > 0) ? done_q[0] - t0 : -1, N + 4);
    check_eq({tag, "_wr_count"}, wr_q.size(), N);
    check_eq({tag, "_rd_count"}, rd_q.size(), N);
    for (int k = 0; k < N; k++) seen[k] = 1'b0;
    nuniq = 0;
    for (int k = 0; k < wr_q.size() && k < N; k++) begin
      check_eq({tag, "_wr_addr"}, wr_q[k].addr, k);
      check_eq({tag, "_wr_cycle"}, wr_q[k].cyc - t0, 4 + k);
      check_eq({tag, "_wr_data"}, wr_q[k].data, ref_diff(int'(mem_a[k]), int'(mem_b[k])));
      if (!seen[wr_q[k].addr]) nuniq++;
      seen[wr_q[k].addr] = 1'b1;
    end
    check_eq({tag, "_wr_unique"}, nuniq, N);
    for (int k = 0; k < rd_q.size() && k < N; k++) begin
      check_eq({tag, "_rd_addr"}, rd_q[k].addr, k);
      check_eq({tag, "_rd_cycle"}, rd_q[k].cyc - t0, 1 + k);
    end
    busy_sum = 0;
    for (int c = t0 + 1; c <= t0 + N + 4; c++) busy_sum += int'(busy_log[c]);
    check_eq({tag, "_busy_before"}, busy_log[t0], 0);
    check_eq({tag, "_busy_span"}, busy_sum, N + 4);
    check_eq({tag, "_busy_after"}, busy_log[t0 + N + 5], 0);
    check_eq({tag, "_rd_addr_hold"}, bus.ext_read_addr, N - 1);
    check_eq({tag, "_rd_valid_idle"}, bus.ext_read_addr_valid, 0);
  endtask

  task automatic reset_mid_pass();
    int t0;
    int nz;
    clear_logs();
    t0 = cyc;
    bus.start_in = 1'b1;
    @(negedge clk); #1;
    bus.start_in = 1'b0;
    while (cyc < t0 + 8) begin
      @(negedge clk); #1;
    end
    check_eq("rst_pre_reads", rd_q.size(), 8);
    check_eq("rst_pre_writes", wr_q.size(), 5);
    clear_logs();
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    repeat (30) begin
      @(negedge clk); #1;
    end
    nz = 0;
    for (int c = t0 + 9; c < t0 + 39; c++) nz += int'(out_log[c]);
    check_eq("rst_outputs_zero_cycles", nz, 0);
    check_eq("rst_no_writes", wr_q.size(), 0);
    check_eq("rst_no_reads", rd_q.size(), 0);
    check_eq("rst_no_done", done_q.size(), 0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) begin
      mem_a[i] = 8'($urandom_range(0, 255));
      mem_b[i] = 8'($urandom_range(0, 255));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_in = 1'b0;
    for (int i = 0; i < N; i++) begin
      mem_a[i] = 8'd0;
      mem_b[i] = 8'd0;
    end
    repeat (3) @(negedge clk);
    #1;
    check_eq("reset_busy", bus.busy_out, 0);
    check_eq("reset_done", bus.dog_done, 0);
    check_eq("reset_rd_valid", bus.ext_read_addr_valid, 0);
    check_eq("reset_rd_addr", bus.ext_read_addr, 0);
    check_eq("reset_wr_valid", bus.ext_write_valid, 0);
    check_eq("reset_wr_pix", bus.ext_pixel_out, 0);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk); #1;
    end

    for (int i = 0; i < N; i++) begin
      mem_a[i] = 8'd100;
      mem_b[i] = 8'd40;
    end
    run_pass("const_pos", 0);

    for (int i = 0; i < N; i++) begin
      mem_a[i] = (i % 2 == 0) ? 8'd0 : 8'd255;
      mem_b[i] = (i % 2 == 0) ? 8'd255 : 8'd0;
    end
    run_pass("extremes", 0);

    for (int i = 0; i < N; i++) begin
      mem_a[i] = 8'd10;
      mem_b[i] = 8'd200;
    end
    run_pass("neg_190", 0);

    for (int i = 0; i < N; i++) begin
      mem_a[i] = 8'(i * 8);
      mem_b[i] = 8'(i);
    end
    run_pass("ramp", 0);

    fill_random();
    run_pass("start_busy", 6);

    reset_mid_pass();
    fill_random();
    run_pass("after_reset", 0);

    fill_random();
    run_pass("b2b_first", 0);
    run_pass("b2b_second", 0);

    repeat (4) begin
      fill_random();
      run_pass("random", 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
